// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - memory-mapped GPIO bank with tri-state outputs and edge interrupts
module gpio_bank #(
   parameter int          N_OUT = 4,
   parameter int          N_IN  = 1,
   parameter logic [29:0] BASE  = 30'h4010
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [29:0]       addr,
   input  logic [31:0]       wdata,
   input  logic [3:0]        we,
   input  logic              re,
   output logic [31:0]       rdata,
   output logic              rsel,
   input  logic [N_IN-1:0]   pin_in,
   output logic [N_OUT-1:0]  out_val,
   output logic [N_OUT-1:0]  out_oe,
   output logic              irq
);

   localparam logic [31:0] RISE_MASK = (N_IN >= 32) ? 32'hFFFF_FFFF : ((32'h1 << N_IN) - 32'h1);
   localparam logic [31:0] FALL_MASK = (N_IN <= 16) ? (RISE_MASK << 16) : 32'h0;
   localparam logic [31:0] IEN_MASK  = RISE_MASK | FALL_MASK;

   logic [N_OUT-1:0] out_q, out_d;
   logic [N_OUT-1:0] oe_q, oe_d;
   logic [31:0]      ien_q, ien_d;
   logic [N_IN-1:0]  rise_q, rise_d;
   logic [N_IN-1:0]  fall_q, fall_d;
   logic [N_IN-1:0]  sync1_q, sync2_q, prev_q;
   logic [1:0]       arm_q, arm_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             rsel_q, rsel_d;
   logic             irq_q, irq_d;

   logic             hit, wr_en, armed;
   logic [3:0]       off;
   logic [N_IN-1:0]  rise_det, fall_det, rise_clr, fall_clr, ien_fall;
   logic [31:0]      rd_val;

   // Fall enables live at bits [N_IN+15:16] only when they fit in the word.
   generate
      if (N_IN <= 16) begin : g_fall_en
         assign ien_fall = ien_q[N_IN+15:16];
      end else begin : g_no_fall_en
         assign ien_fall = '0;
      end
   endgenerate

   always_comb begin
      hit      = (addr[29:4] == BASE[29:4]);
      off      = addr[3:0];
      wr_en    = hit && (we == 4'hF);
      armed    = (arm_q == 2'd3);
      rise_det = armed ? (sync2_q & ~prev_q) : '0;
      fall_det = armed ? (~sync2_q & prev_q) : '0;
      arm_d    = armed ? arm_q : arm_q + 2'd1;

      out_d    = out_q;
      oe_d     = oe_q;
      ien_d    = ien_q;
      rise_clr = '0;
      fall_clr = '0;
      if (wr_en) begin
         case (off)
            4'd0: out_d = wdata[N_OUT-1:0];
            4'd1: oe_d  = wdata[N_OUT-1:0];
            4'd2: out_d = out_q | wdata[N_OUT-1:0];
            4'd3: out_d = out_q & ~wdata[N_OUT-1:0];
            4'd4: out_d = out_q ^ wdata[N_OUT-1:0];
            4'd6: rise_clr = wdata[N_IN-1:0];
            4'd7: fall_clr = wdata[N_IN-1:0];
            4'd8: ien_d = wdata & IEN_MASK;
            default: ;
         endcase
      end
      // A newly detected edge outranks a coincident write-1-to-clear.
      rise_d = (rise_q & ~rise_clr) | rise_det;
      fall_d = (fall_q & ~fall_clr) | fall_det;

      rd_val = '0;
      case (off)
         4'd0: rd_val = 32'(out_q);
         4'd1: rd_val = 32'(oe_q);
         4'd5: rd_val = 32'(sync2_q);
         4'd6: rd_val = 32'(rise_q);
         4'd7: rd_val = 32'(fall_q);
         4'd8: rd_val = ien_q;
         default: ;
      endcase
      rsel_d  = re && hit;
      rdata_d = rsel_d ? rd_val : '0;
      irq_d   = (|(rise_q & ien_q[N_IN-1:0])) | (|(fall_q & ien_fall));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q   <= '0;
         oe_q    <= '0;
         ien_q   <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         arm_q   <= '0;
         rdata_q <= '0;
         rsel_q  <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         out_q   <= out_d;
         oe_q    <= oe_d;
         ien_q   <= ien_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         sync1_q <= pin_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         arm_q   <= arm_d;
         rdata_q <= rdata_d;
         rsel_q  <= rsel_d;
         irq_q   <= irq_d;
      end
   end

   assign out_val = out_q;
   assign out_oe  = oe_q;
   assign rdata   = rdata_q;
   assign rsel    = rsel_q;
   assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// tb/tb_gpio_bank.sv - self-checking bench for gpio_bank with a pad-history reference model
module tb_gpio_bank;

   localparam logic [29:0] BASE = 30'h4010;

   logic        clk;
   logic        reset;
   logic [29:0] addr;
   logic [31:0] wdata;
   logic [3:0]  we;
   logic        re;
   logic [31:0] rdata;
   logic        rsel;
   logic [0:0]  pin_in;
   logic [3:0]  out_val;
   logic [3:0]  out_oe;
   logic        irq;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_on  = 0;

   gpio_bank #(.N_OUT(4), .N_IN(1), .BASE(BASE)) dut (
      .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
      .rdata(rdata), .rsel(rsel), .pin_in(pin_in), .out_val(out_val),
      .out_oe(out_oe), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: registers as plain values, edges from the pad samples of
   // two and three edges ago, edges counted only from the fourth edge after reset.
   logic [3:0]  m_out, m_oe;
   logic [31:0] m_ien, m_rdata;
   logic        m_rise, m_fall, m_irq, m_rsel;
   logic        m_p1, m_p2, m_p3;
   int          m_j;
   logic        m_hit, m_w, m_dr, m_df;
   logic [3:0]  m_off;

   assign m_hit = (addr[29:4] == BASE[29:4]);
   assign m_off = addr[3:0];
   assign m_w   = m_hit && (we == 4'hF);
   assign m_dr  = (m_j >= 3) && m_p2 && !m_p3;
   assign m_df  = (m_j >= 3) && !m_p2 && m_p3;

   function automatic logic [31:0] m_read(input logic [3:0] o);
      case (o)
         4'd0: return {28'd0, m_out};
         4'd1: return {28'd0, m_oe};
         4'd5: return {31'd0, m_p2};
         4'd6: return {31'd0, m_rise};
         4'd7: return {31'd0, m_fall};
         4'd8: return m_ien;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_out <= 0; m_oe <= 0; m_ien <= 0; m_rise <= 0; m_fall <= 0;
         m_irq <= 0; m_rsel <= 0; m_rdata <= 0;
         m_p1 <= 0; m_p2 <= 0; m_p3 <= 0; m_j <= 0;
      end else begin
         m_j     <= (m_j < 8) ? m_j + 1 : m_j;
         m_rsel  <= re && m_hit;
         m_rdata <= (re && m_hit) ? m_read(m_off) : 32'd0;
         m_irq   <= (m_rise && m_ien[0]) || (m_fall && m_ien[16]);
         if (m_w) begin
            case (m_off)
               4'd0: m_out <= wdata[3:0];
               4'd1: m_oe  <= wdata[3:0];
               4'd2: m_out <= m_out | wdata[3:0];
               4'd3: m_out <= m_out & ~wdata[3:0];
               4'd4: m_out <= m_out ^ wdata[3:0];
               4'd8: m_ien <= wdata & 32'h0001_0001;
               default: ;
            endcase
         end
         m_rise <= (m_rise && !(m_w && m_off == 4'd6 && wdata[0])) || m_dr;
         m_fall <= (m_fall && !(m_w && m_off == 4'd7 && wdata[0])) || m_df;
         m_p3 <= m_p2;
         m_p2 <= m_p1;
         m_p1 <= pin_in[0];
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("model_out_val", 32'(out_val), 32'(m_out));
         check("model_out_oe",  32'(out_oe),  32'(m_oe));
         check("model_irq",     32'(irq),     32'(m_irq));
         check("model_rsel",    32'(rsel),    32'(m_rsel));
         check("model_rdata",   rdata,        m_rdata);
      end
   end

   function automatic logic [29:0] a(input int off);
      return {BASE[29:4], 4'(off)};
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic wr(input int off, input logic [31:0] d, input logic [3:0] be = 4'hF);
      addr = a(off); wdata = d; we = be;
      step();
      we = 4'h0; wdata = 32'h0;
   endtask

   task automatic rd(input int off, input logic [31:0] exp, input string nm);
      addr = a(off); re = 1'b1;
      step();
      re = 1'b0;
      @(negedge clk);
      check({nm, "_rsel"}, 32'(rsel), 32'd1);
      check(nm, rdata, exp);
   endtask

   initial begin
      reset = 1'b1; pin_in = 1'b1; re = 1'b1; addr = a(0); wdata = 0; we = 4'h0;
      step();
      chk_on = 1;
      idle(2);
      @(negedge clk);
      check("reset_rsel_during_read", 32'(rsel), 32'd0);
      check("reset_rdata", rdata, 32'd0);
      check("reset_out_val", 32'(out_val), 32'd0);
      check("reset_irq", 32'(irq), 32'd0);
      reset = 1'b0; re = 1'b0;

      // pad held high through reset: IN follows, no RISE
      idle(2);
      rd(5, 32'd1, "in_sync_high");
      idle(3);
      rd(6, 32'd0, "rise_held_through_reset");

      wr(1, 32'h5);
      wr(0, 32'h3);
      @(negedge clk);
      check("out_oe_0101", 32'(out_oe), 32'h5);
      check("out_val_0011", 32'(out_val), 32'h3);
      rd(0, 32'h3, "read_out");

      wr(0, 32'hA);
      wr(2, 32'h1);
      wr(3, 32'h8);
      wr(4, 32'h6);
      rd(0, 32'h5, "set_clr_tgl");

      // rising edge with IEN bit0: RISE after 3 edges, irq one later
      wr(8, 32'h1);
      pin_in = 1'b0;
      idle(5);
      wr(7, 32'h1);
      pin_in = 1'b1;
      idle(3);
      @(negedge clk);
      check("irq_before_rise", 32'(irq), 32'd0);
      rd(6, 32'd1, "rise_pending");
      check("irq_after_rise", 32'(irq), 32'd1);
      wr(6, 32'h1);
      @(negedge clk);
      check("irq_holds_on_w1c_edge", 32'(irq), 32'd1);
      step();
      @(negedge clk);
      check("irq_drops", 32'(irq), 32'd0);
      rd(6, 32'd0, "rise_cleared");

      // W1C coinciding with a new detected edge
      pin_in = 1'b0;
      idle(5);
      wr(7, 32'h1);
      pin_in = 1'b1;
      idle(2);
      wr(6, 32'h1);
      rd(6, 32'd1, "rise_set_wins");

      // falling edge with fall enable
      wr(8, 32'h0001_0000);
      rd(8, 32'h0001_0000, "ien_fall_bit");
      pin_in = 1'b0;
      idle(4);
      rd(7, 32'd1, "fall_pending");
      check("irq_fall", 32'(irq), 32'd1);
      wr(8, 32'hFFFF_FFFF);
      rd(8, 32'h0001_0001, "ien_masked");

      // partial writes, ignored offsets, zero reads
      wr(0, 32'hF, 4'b0011);
      wr(7, 32'h1, 4'b1110);
      wr(9, 32'hFFFF_FFFF);
      wr(5, 32'hFFFF_FFFF);
      rd(0, 32'h5, "partial_write_ignored");
      rd(7, 32'd1, "partial_w1c_ignored");
      rd(12, 32'd0, "off12_zero");
      rd(2, 32'd0, "set_reads_zero");

      // read and write same offset in one cycle returns old value
      addr = a(0); wdata = 32'h9; we = 4'hF; re = 1'b1;
      step();
      we = 4'h0; re = 1'b0;
      @(negedge clk);
      check("rw_same_cycle_old", rdata, 32'h5);
      rd(0, 32'h9, "rw_new_value");

      // miss
      addr = {BASE[29:4] + 26'd1, 4'd0}; re = 1'b1;
      step();
      re = 1'b0;
      @(negedge clk);
      check("miss_rsel", 32'(rsel), 32'd0);
      check("miss_rdata", rdata, 32'd0);

      // reset beats a coincident write
      reset = 1'b1; addr = a(0); wdata = 32'hF; we = 4'hF;
      step();
      reset = 1'b0; we = 4'h0;
      @(negedge clk);
      check("reset_priority_out", 32'(out_val), 32'd0);
      check("reset_priority_oe", 32'(out_oe), 32'd0);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
